// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the two-port data RAM arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, ACCESS, RESP)
//   - ADDR_W_DEFAULT / DATA_W_DEFAULT : default RAM address / data widths
// Configuration macro: RAM_ARB_FIXED_PRIO_EN (consumed by rr_arb2 and ram_arbiter).
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 16;
    localparam int unsigned DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester winner select, one-hot grant out (combinational).
// Ports:
//   last_gnt  in  1  port granted most recently (0 = CPU, 1 = aux); absent in fixed mode
//   req       in  2  request vector, bit 0 = CPU port, bit 1 = aux port
//   gnt       out 2  one-hot winner, all-zero when no request
// Configuration macro: RAM_ARB_FIXED_PRIO_EN -- when defined the CPU port always wins
// ties and the last_gnt input does not exist.
module rr_arb2 (
`ifndef RAM_ARB_FIXED_PRIO_EN
    input  logic       last_gnt,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            gnt = 2'b01;
`else
            // Tie: favour the port that did not win last time.
            gnt = last_gnt ? 2'b01 : 2'b10;
`endif
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous-read data RAM between a CPU port (0) and an
// auxiliary loader/debug port (1).
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0          CPU request, write enable, address, write data
//   gnt0/rvalid0/rdata0            CPU grant pulse, read-valid pulse, read data
//   req1/we1/addr1/wdata1          aux request side (same meaning as port 0)
//   gnt1/rvalid1/rdata1            aux response side (same meaning as port 0)
//   ram_addr/ram_wdata/ram_we      RAM command outputs (registered)
//   ram_rdata                      RAM read data, valid one cycle after ram_addr
// Sequence: IDLE -> ACCESS (gnt, ram_we for writes) -> IDLE for writes,
//           IDLE -> ACCESS -> RESP (rvalid) -> IDLE for reads.
// Configuration macro: RAM_ARB_FIXED_PRIO_EN -- fixed CPU priority, no last_gnt register.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    // CPU port
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    // Aux port
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    // Data RAM
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_e state_q;
    logic       sel_q;   // port owning the transfer in flight
    logic [1:0] win;

`ifndef RAM_ARB_FIXED_PRIO_EN
    logic last_gnt_q;
`endif

    rr_arb2 u_rr_arb2 (
`ifndef RAM_ARB_FIXED_PRIO_EN
        .last_gnt (last_gnt_q),
`endif
        .req      ({req1, req0}),
        .gnt      (win)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_gnt_q <= 1'b1;   // CPU wins the first tie
`endif
        end else begin
            // Pulses default low; ram_addr/ram_wdata hold unless a new grant loads them.
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            ram_we  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (win != 2'b00) begin
                        state_q   <= ACCESS;
                        sel_q     <= win[1];
                        gnt0      <= win[0];
                        gnt1      <= win[1];
                        ram_we    <= win[1] ? we1    : we0;
                        ram_addr  <= win[1] ? addr1  : addr0;
                        ram_wdata <= win[1] ? wdata1 : wdata0;
`ifndef RAM_ARB_FIXED_PRIO_EN
                        last_gnt_q <= win[1];
`endif
                    end
                end
                ACCESS: begin
                    if (ram_we) begin
                        state_q <= IDLE;
                    end else begin
                        // RAM samples ram_addr on this edge; data appears during RESP.
                        state_q <= RESP;
                        rvalid0 <= ~sel_q;
                        rvalid1 <= sel_q;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM read data is only visible to the port being answered.
    assign rdata0 = rvalid0 ? ram_rdata : '0;
    assign rdata1 = rvalid1 ? ram_rdata : '0;

endmodule
